// File: rtl/disp_scan_scheduler.sv
// Multiplexed 3-digit 7-segment driver: 10-bit value in over valid/ready,
// sequential double-dabble to BCD, frame-aligned commit, blanking and LZ suppression.
module disp_scan_scheduler #(
  parameter int unsigned CLK_FREQ     = 27_000_000,
  parameter int unsigned DIGIT_CYCLES = 216_000,
  parameter int unsigned BLANK_CYCLES = 2_700,
  parameter int unsigned LZ_SUPPRESS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [9:0] value_i,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       ovf_o,
  output logic       frame_o
);

  localparam int unsigned CW       = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [9:0] VAL_MAX   = 10'd999;
  localparam logic [3:0] N_ITER    = 4'd10;
  localparam logic [1:0] IDX_UNITS = 2'd0;
  localparam logic [1:0] IDX_TENS  = 2'd1;
  localparam logic [1:0] IDX_HUND  = 2'd2;
  localparam bit         LZ_EN     = (LZ_SUPPRESS != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  // Elaboration-time guard against an unusable configuration.
  if (CLK_FREQ == 0 || DIGIT_CYCLES == 0 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_cfg
    $error("disp_scan_scheduler: illegal CLK_FREQ/DIGIT_CYCLES/BLANK_CYCLES");
  end

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [11:0]   disp, disp_nxt;
  logic [1:0]    state, state_nxt;
  logic [9:0]    bin, bin_nxt;
  logic [11:0]   bcd, bcd_nxt;
  logic [3:0]    iter, iter_nxt;
  logic          ovf_nxt;
  logic [2:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          frame_nxt;
  logic          slot_wrap, frame_wrap, in_blank;

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign load_ready = (state == S_IDLE);
  assign slot_wrap  = (cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_HUND);

  always_comb begin : scan_next
    cnt_nxt = slot_wrap ? '0 : cnt + CW'(1);
    idx_nxt = idx;
    if (slot_wrap) idx_nxt = (idx >= IDX_HUND) ? IDX_UNITS : idx + 2'd1;
  end

  always_comb begin : fsm_next
    state_nxt = state;
    bin_nxt   = bin;
    bcd_nxt   = bcd;
    iter_nxt  = iter;
    ovf_nxt   = ovf_o;
    disp_nxt  = disp;
    case (state)
      S_IDLE: begin
        if (load_valid) begin
          state_nxt = S_CONV;
          bin_nxt   = (value_i > VAL_MAX) ? VAL_MAX : value_i;
          ovf_nxt   = (value_i > VAL_MAX);
          bcd_nxt   = '0;
          iter_nxt  = N_ITER;
        end
      end
      S_CONV: begin
        {bcd_nxt, bin_nxt} = {dd_adjust(bcd), bin} << 1;
        iter_nxt = iter - 4'd1;
        if (iter == 4'd1) state_nxt = S_PEND;
      end
      S_PEND: begin
        if (frame_wrap) begin
          disp_nxt  = bcd;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  if (BLANK_CYCLES == 0) begin : g_noblank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (32'(cnt_nxt) < BLANK_CYCLES);
  end

  // Outputs are computed from next-cycle scan state so an/seg line up with the counter.
  always_comb begin : out_next
    logic [3:0] dig;
    logic       sup;
    logic [2:0] an_sel;
    dig       = disp_nxt[3:0];
    sup       = 1'b0;
    an_sel    = 3'b001;
    frame_nxt = (idx_nxt == IDX_UNITS) && (cnt_nxt == '0);
    case (idx_nxt)
      IDX_TENS: begin
        an_sel = 3'b010;
        dig    = disp_nxt[7:4];
        sup    = LZ_EN && (disp_nxt[11:8] == 4'd0) && (disp_nxt[7:4] == 4'd0);
      end
      IDX_HUND: begin
        an_sel = 3'b100;
        dig    = disp_nxt[11:8];
        sup    = LZ_EN && (disp_nxt[11:8] == 4'd0);
      end
      default: begin
        an_sel = 3'b001;
        dig    = disp_nxt[3:0];
      end
    endcase
    if (in_blank) begin
      an_nxt  = 3'b000;
      seg_nxt = SEG_BLANK;
    end else begin
      an_nxt  = an_sel;
      seg_nxt = sup ? SEG_BLANK : seg_dec(dig);
    end
  end

  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= IDX_UNITS;
      disp    <= '0;
      bin     <= '0;
      bcd     <= '0;
      iter    <= '0;
      ovf_o   <= 1'b0;
      an      <= 3'b000;
      seg     <= SEG_BLANK;
      frame_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      disp    <= disp_nxt;
      bin     <= bin_nxt;
      bcd     <= bcd_nxt;
      iter    <= iter_nxt;
      ovf_o   <= ovf_nxt;
      an      <= an_nxt;
      seg     <= seg_nxt;
      frame_o <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_disp_scan_scheduler.sv
// Scoreboard bench for disp_scan_scheduler: one instance with blanking and LZ suppression,
// one with both disabled.
module tb_disp_scan_scheduler;

  localparam int unsigned D = 20;

  typedef struct packed {
    logic       ovf;
    logic [6:0] u;
    logic [6:0] t;
    logic [6:0] h;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, lv_a, lr_a, ovf_a, fo_a;
  logic [9:0] val_a;
  logic [2:0] an_a;
  logic [6:0] seg_a;
  logic       rst_b, lv_b, lr_b, ovf_b, fo_b;
  logic [9:0] val_b;
  logic [2:0] an_b;
  logic [6:0] seg_b;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  disp_scan_scheduler #(.CLK_FREQ(27_000_000), .DIGIT_CYCLES(D), .BLANK_CYCLES(4), .LZ_SUPPRESS(1)) u_dut (
    .clk(clk), .rst_n(rst_a), .load_valid(lv_a), .load_ready(lr_a), .value_i(val_a),
    .an(an_a), .seg(seg_a), .ovf_o(ovf_a), .frame_o(fo_a)
  );

  disp_scan_scheduler #(.CLK_FREQ(27_000_000), .DIGIT_CYCLES(D), .BLANK_CYCLES(0), .LZ_SUPPRESS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_b), .load_valid(lv_b), .load_ready(lr_b), .value_i(val_b),
    .an(an_b), .seg(seg_b), .ovf_o(ovf_b), .frame_o(fo_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t mk_exp(input int v, input bit lz);
    exp_t e;
    int   vv, u, t, h;
    vv    = (v > 999) ? 999 : v;
    u     = vv % 10;
    t     = (vv / 10) % 10;
    h     = vv / 100;
    e.ovf = (v > 999);
    e.u   = seg_of(u);
    e.t   = (lz && h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
    e.h   = (lz && h == 0) ? 7'b1111111 : seg_of(h);
    return e;
  endfunction

  function automatic logic rdy(input bit nb);
    return nb ? lr_b : lr_a;
  endfunction

  function automatic logic fo(input bit nb);
    return nb ? fo_b : fo_a;
  endfunction

  function automatic logic ovf(input bit nb);
    return nb ? ovf_b : ovf_a;
  endfunction

  task automatic set_in(input bit nb, input int v, input logic valid);
    if (nb) begin
      lv_b  = valid;
      val_b = 10'(v);
    end else begin
      lv_a  = valid;
      val_a = 10'(v);
    end
  endtask

  task automatic wait_ready(input bit nb, input string tag);
    int n = 0;
    while (!rdy(nb) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rdy(nb)), 32'd1);
  endtask

  // Check one full frame of {frame_o, an, seg}, starting at the next frame_o pulse.
  task automatic scan_frame(input bit nb, input exp_t e, input int blank, input string tag);
    int         n = 0;
    int         slot, cc;
    logic [2:0] an_e;
    logic [6:0] seg_e;
    while (!fo(nb) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sync"}, 32'(fo(nb)), 32'd1);
    for (int k = 0; k < 3 * D; k++) begin
      if (k > 0) @(negedge clk);
      slot  = k / D;
      cc    = k % D;
      an_e  = (cc < blank) ? 3'b000 : 3'(1 << slot);
      seg_e = (cc < blank) ? 7'b1111111 : (slot == 0) ? e.u : (slot == 1) ? e.t : e.h;
      if (nb) check(tag, 32'({fo_b, an_b, seg_b}), 32'({k == 0, an_e, seg_e}));
      else    check(tag, 32'({fo_a, an_a, seg_a}), 32'({k == 0, an_e, seg_e}));
    end
  endtask

  task automatic do_load(input bit nb, input int v, input bit hold, input bit lz);
    wait_ready(nb, "ready_before_load");
    set_in(nb, v, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) set_in(nb, v, 1'b0);
    check("ovf_after_xfer", 32'(ovf(nb)), 32'(v > 999));
    check("ready_low_after_xfer", 32'(rdy(nb)), 32'd0);
    if (nb) sb_b.push_back(mk_exp(v, lz));
    else    sb_a.push_back(mk_exp(v, lz));
  endtask

  task automatic commit_scan(input bit nb, input int blank, input string tag);
    exp_t e;
    wait_ready(nb, {tag, "_commit"});
    check({tag, "_commit_on_frame"}, 32'(fo(nb)), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(nb ? sb_b.size() : sb_a.size()), 32'd1);
    e = nb ? sb_b.pop_front() : sb_a.pop_front();
    check({tag, "_ovf"}, 32'(ovf(nb)), 32'(e.ovf));
    scan_frame(nb, e, blank, tag);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    exp_t e42, e600;
    rst_a = 1'b0; rst_b = 1'b0;
    set_in(0, 0, 1'b0);
    set_in(1, 0, 1'b0);

    // Reset and idle scan
    repeat (3) begin
      @(negedge clk);
      check("reset_an", 32'(an_a), 32'd0);
      check("reset_seg", 32'(seg_a), 32'h7f);
      check("reset_ovf", 32'(ovf_a), 32'd0);
      check("reset_frame", 32'(fo_a), 32'd0);
    end
    rst_a = 1'b1; rst_b = 1'b1;
    check("ready_after_reset", 32'(lr_a), 32'd1);
    scan_frame(0, mk_exp(0, 1), 4, "idle_frame0");
    @(negedge clk);
    scan_frame(0, mk_exp(0, 1), 4, "idle_frame1");

    // Load 305
    do_load(0, 305, 0, 1);
    commit_scan(0, 4, "v305");

    // Saturation, then a small value
    do_load(0, 1023, 0, 1);
    commit_scan(0, 4, "v1023");
    do_load(0, 7, 0, 1);
    commit_scan(0, 4, "v7");

    // Backpressure: 600 held valid while 42 converts and waits
    do_load(0, 42, 1, 1);
    set_in(0, 600, 1'b1);
    sb_a.push_back(mk_exp(600, 1));
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_low", 32'(lr_a), 32'd0);
    end
    wait_ready(0, "bp_commit42");
    check("bp_commit_on_frame", 32'(fo_a), 32'd1);
    e42  = sb_a.pop_front();
    e600 = sb_a.pop_front();
    fork
      scan_frame(0, e42, 4, "bp_frame42");
      begin
        @(posedge clk);
        @(negedge clk);
        check("bp_accept_first_edge", 32'(lr_a), 32'd0);
        set_in(0, 600, 1'b0);
      end
    join
    @(negedge clk);
    check("bp_commit600_ready", 32'(lr_a), 32'd1);
    scan_frame(0, e600, 4, "bp_frame600");

    // Reset in the 5th conversion cycle
    wait_ready(0, "ready_before_888");
    set_in(0, 888, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 888, 1'b0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midconv_reset_an", 32'(an_a), 32'd0);
      check("midconv_reset_seg", 32'(seg_a), 32'h7f);
    end
    rst_a = 1'b1;
    check("midconv_ready", 32'(lr_a), 32'd1);
    check("midconv_ovf", 32'(ovf_a), 32'd0);
    scan_frame(0, mk_exp(0, 1), 4, "midconv_frame0");
    @(negedge clk);
    scan_frame(0, mk_exp(0, 1), 4, "midconv_frame1");

    // No blanking, no suppression
    scan_frame(1, mk_exp(0, 0), 0, "nb_idle");
    do_load(1, 5, 0, 0);
    commit_scan(1, 0, "nb_v5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/disp_scan_scheduler.md
Name: disp_scan_scheduler

Overview:
- Drives the 3-digit multiplexed 7-segment display from a binary value.
- Accepts a 10-bit value over a valid/ready handshake and converts it to BCD sequentially (double-dabble).
- Commits new digits only at frame boundaries, so no tearing.
- Time-multiplexes the anodes with a per-digit blanking window for anti-ghosting, and suppresses leading zeros.

Parameters:
- CLK_FREQ, 27_000_000: input clock frequency in Hz; informational only.
- DIGIT_CYCLES, 216_000: clock cycles per digit slot (8 ms at 27 MHz).
- BLANK_CYCLES, 2_700: cycles at the start of each slot with all anodes off. Legal range 0 to DIGIT_CYCLES-1; 0 disables blanking.
- LZ_SUPPRESS, 1: 1 blanks leading zeros; 0 always shows all digits.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, synchronous, active-low.
- load_valid, input, 1: new value offered.
- load_ready, output, 1: block can accept a value.
- value_i, input, 10: binary value (0..1023).
- an, output, 3: anode select, one-hot, active-high. an[0] is units, an[1] tens, an[2] hundreds.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- ovf_o, output, 1: last accepted value exceeded 999.
- frame_o, output, 1: one-cycle pulse at the start of each frame (units slot, count 0).

Behaviour:
- **Clock and reset:**
  - One clock; reset is synchronous and active-low.
  - On a clk edge with rst_n=0, all of the following are set:
    - an=000, seg=1111111, ovf_o=0, frame_o=0.
    - Slot counter=0, digit index=0.
    - Display BCD register=000, pending flag cleared, conversion FSM=IDLE.
  - Reset mid-conversion aborts it; the result is discarded.
- **Scan timing:**
  - Slot counter runs 0..DIGIT_CYCLES-1, then wraps and advances the digit index 0→1→2→0.
  - Frame = 3 slots = 3*DIGIT_CYCLES cycles.
  - an and seg are registered and change on the same edge.
  - Counter value c < BLANK_CYCLES: an=000, seg=1111111.
  - Otherwise: an=one-hot(index), seg=decode(digit[index]).
  - frame_o=1 for exactly the cycle where index=0 and c=0.
- **Segment decode (gfedcba, active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Blank=1111111.
- **Leading-zero suppression (LZ_SUPPRESS=1):**
  - Hundreds is blanked when it is 0.
  - Tens is blanked when hundreds=0 and tens=0.
  - Units is never blanked.
  - A suppressed digit keeps its anode asserted with seg=1111111.
- **Conversion FSM, states IDLE, CONV, PEND:**
  - load_ready = (state==IDLE), combinational decode. A transfer occurs on an edge with load_valid & load_ready & rst_n.
  - IDLE→CONV on transfer:
    - Latch min(value_i, 999).
    - ovf_o <= (value_i > 999), held until the next transfer.
    - Clear the 12-bit BCD scratch register and load the iteration counter with 10.
  - CONV, one iteration per cycle:
    - Add 3 to each BCD nibble that is ≥5.
    - Then shift {bcd, bin} left by 1.
    - After the 10th iteration (10 cycles after the transfer edge), go to PEND.
  - PEND→IDLE on the frame-boundary edge, i.e. the edge where index wraps 2→0 and c wraps to 0. On that edge the display register <= scratch.
    - If PEND is entered on that very edge, commit waits for the following frame boundary.
  - load_ready is low throughout CONV and PEND. load_valid held during that time is ignored, with no loss; the producer must hold value_i stable until the transfer.
  - New digits become visible from the units slot that starts at the commit edge, after its blanking window.
- **Widths:**
  - Slot counter width is $clog2(DIGIT_CYCLES).
  - Digit index is 2 bits; value 3 is unreachable and treated as 0.

Test Plan (DIGIT_CYCLES=20, BLANK_CYCLES=4, LZ_SUPPRESS=1 unless stated):
1. **Reset and idle scan.** Stimulus: hold rst_n=0 for 3 cycles, then release. Required response:
   - During reset: an=000, seg=1111111.
   - After release: slot 0 shows an=000 for 4 cycles, then an=001 with seg=1000000 for 16 cycles.
   - Tens and hundreds slots: an=010 / 100 with seg=1111111.
   - Anode period is 20 cycles per digit; frame_o pulses every 60 cycles.
2. **Load 305.** Stimulus: load 305 while idle. Required response:
   - load_ready low from the cycle after the transfer until the commit.
   - After the next frame_o: units seg=0010010, tens seg=1000000 (not suppressed), hundreds seg=0110000.
3. **Saturation.** Stimulus: load 1023, then load 7. Required response:
   - After 1023: ovf_o=1, display shows 9,9,9.
   - After 7: ovf_o=0 immediately after that transfer; display shows units=1111000, tens and hundreds blank.
4. **Backpressure.** Stimulus: after loading 42, hold load_valid=1 with value 600. Required response:
   - No transfer while load_ready=0.
   - 600 is accepted on the first edge after the commit of 42.
   - 42 is displayed for exactly one frame, then 600.
5. **Reset mid-conversion.** Stimulus: load 888, assert rst_n=0 at the 5th CONV cycle. Required response:
   - Display stays 000 (shows "0"), ovf_o=0.
   - load_ready=1 once reset releases.
6. **Blanking and suppression disabled.** Stimulus: LZ_SUPPRESS=0, BLANK_CYCLES=0, load 5. Required response:
   - an is never 000 after reset.
   - Digits read 0,0,5 with hundreds and tens seg=1000000.
